// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, LSB-first byte assembly.
// Latency: rx_vld rises ~953 clocks after the start-bit falling edge at 100 MHz / 1 Mbaud.
// Backpressure: one-byte valid/ready holding register; a byte completed while full is dropped with rx_ovr.
module uart_rx_byte #(
  parameter int CLK_FREQ     = 100000000,
  parameter int BAUD         = 1000000,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       rx_rdy,
  output logic [7:0] rx_data,
  output logic       rx_vld,
  output logic       rx_ferr,
  output logic       rx_ovr,
  output logic       rx_busy
);

  // Bit-timer width; guard the degenerate single-clock case so the vector is never zero wide.
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  // Terminal counts: half a bit lands the start-bit check in its centre, a full bit
  // then steps from centre to centre of every following bit.
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [1:0]    sync_q;
  logic          rx_s;

  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    bidx, bidx_nxt;
  logic [7:0]    shreg, shreg_nxt;

  logic [7:0]    data_q, data_nxt;
  logic          vld_q, vld_nxt;
  logic          ferr_q, ferr_nxt;
  logic          ovr_q, ovr_nxt;

  // Two-flop synchronizer for the asynchronous line; preset high so reset release
  // never looks like a falling start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx};
    end
  end

  assign rx_s = sync_q[1];

  // State, timer, shifter and holding register; reset drops any frame in flight silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      bidx   <= '0;
      shreg  <= '0;
      data_q <= '0;
      vld_q  <= 1'b0;
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      bidx   <= bidx_nxt;
      shreg  <= shreg_nxt;
      data_q <= data_nxt;
      vld_q  <= vld_nxt;
      ferr_q <= ferr_nxt;
      ovr_q  <= ovr_nxt;
    end
  end

  // Frame sequencing, sampling decisions and consumer handshake.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    bidx_nxt  = bidx;
    shreg_nxt = shreg;
    data_nxt  = data_q;
    // A held byte is released when the consumer takes it; a load below may re-set it.
    vld_nxt   = vld_q & ~rx_rdy;
    ferr_nxt  = 1'b0;
    ovr_nxt   = 1'b0;

    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (!rx_s) begin
          state_nxt = START;
        end
      end

      START: begin
        if (cnt == CNT_HALF) begin
          cnt_nxt = '0;
          if (!rx_s) begin
            // Still low at mid start bit: a real frame.
            state_nxt = DATA;
            bidx_nxt  = '0;
          end else begin
            // Line went back high: treat as noise, no error reported.
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      DATA: begin
        if (cnt == CNT_FULL) begin
          cnt_nxt   = '0;
          // LSB first: after eight shifts the first data bit sits in bit 0.
          shreg_nxt = {rx_s, shreg[7:1]};
          bidx_nxt  = bidx + 1'b1;
          if (bidx == 3'd7) begin
            state_nxt = STOP;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      STOP: begin
        if (cnt == CNT_FULL) begin
          cnt_nxt = '0;
          if (rx_s) begin
            // Good frame. Return to IDLE straight from mid stop bit so a start bit
            // following immediately is still caught.
            state_nxt = IDLE;
            if (!vld_q || rx_rdy) begin
              data_nxt = shreg;
              vld_nxt  = 1'b1;
            end else begin
              ovr_nxt = 1'b1;
            end
          end else begin
            // Stop bit low: drop the byte, then sit in BREAK so a long low
            // line yields only this one error.
            ferr_nxt  = 1'b1;
            state_nxt = BREAK;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      BREAK: begin
        cnt_nxt = '0;
        if (rx_s) begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign rx_data = data_q;
  assign rx_vld  = vld_q;
  assign rx_ferr = ferr_q;
  assign rx_ovr  = ovr_q;
  assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte at default parameters (100 clocks per bit).
// Inputs driven 1 time unit after posedge; outputs sampled there or by a negedge monitor.
// Each scenario task does its own comparisons; one summary line at the end.
module tb_uart_rx_byte;

  localparam int CPB = 100;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic       rx_rdy;
  logic [7:0] rx_data;
  logic       rx_vld;
  logic       rx_ferr;
  logic       rx_ovr;
  logic       rx_busy;

  int n_cmp = 0;
  int n_bad = 0;

  uart_rx_byte dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .rx      (rx),
    .rx_rdy  (rx_rdy),
    .rx_data (rx_data),
    .rx_vld  (rx_vld),
    .rx_ferr (rx_ferr),
    .rx_ovr  (rx_ovr),
    .rx_busy (rx_busy)
  );

  always #5 clk = ~clk;

  // Free-running cycle counter for latency measurement
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: records each new byte presented, counts flag pulses
  logic [7:0] load_dat_q[$];
  int         load_cyc_q[$];
  int         ferr_cnt   = 0;
  int         ovr_cnt    = 0;
  int         both_cnt   = 0;
  int         ovr_cyc    = 0;
  int         vld_hi_cnt = 0;
  logic       prev_vld   = 1'b0;
  logic       prev_acc   = 1'b0;

  always @(negedge clk) begin
    if (rx_vld && (!prev_vld || prev_acc)) begin
      load_dat_q.push_back(rx_data);
      load_cyc_q.push_back(cyc);
    end
    if (rx_vld) vld_hi_cnt <= vld_hi_cnt + 1;
    if (rx_ferr) ferr_cnt <= ferr_cnt + 1;
    if (rx_ovr) begin
      ovr_cnt <= ovr_cnt + 1;
      ovr_cyc <= cyc;
    end
    if (rx_ferr && rx_ovr) both_cnt <= both_cnt + 1;
    prev_vld <= rx_vld;
    prev_acc <= rx_vld && rx_rdy;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop, output int t0);
    t0 = cyc;
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = stop;
    tick(CPB);
  endtask

  task automatic test_reset;
    int fb, ob;
    rst_n = 1'b0; rx = 1'b1; rx_rdy = 1'b0;
    tick(5);
    n_cmp++; if (rx_vld !== 1'b0) begin n_bad++; $display("FAIL reset_vld: got %b want 0", rx_vld); end
    n_cmp++; if (rx_data !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h want 00", rx_data); end
    n_cmp++; if (rx_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", rx_busy); end
    n_cmp++; if (rx_ferr !== 1'b0) begin n_bad++; $display("FAIL reset_ferr: got %b want 0", rx_ferr); end
    n_cmp++; if (rx_ovr !== 1'b0) begin n_bad++; $display("FAIL reset_ovr: got %b want 0", rx_ovr); end
    fb = ferr_cnt; ob = ovr_cnt;
    rst_n = 1'b1;
    tick(5000);
    n_cmp++; if (rx_vld !== 1'b0) begin n_bad++; $display("FAIL idle_vld: got %b want 0", rx_vld); end
    n_cmp++; if (rx_busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy: got %b want 0", rx_busy); end
    n_cmp++; if (load_dat_q.size() !== 0) begin n_bad++; $display("FAIL idle_loads: got %0d want 0", load_dat_q.size()); end
    n_cmp++; if (ferr_cnt - fb !== 0 || ovr_cnt - ob !== 0) begin n_bad++; $display("FAIL idle_flags: ferr %0d ovr %0d want 0 0", ferr_cnt - fb, ovr_cnt - ob); end
  endtask

  task automatic test_single;
    int base, t0, lat;
    base = load_dat_q.size();
    rx_rdy = 1'b0;
    send_byte(8'hA5, 1'b1, t0);
    tick(50);
    n_cmp++; if (load_dat_q.size() - base !== 1) begin n_bad++; $display("FAIL single_count: got %0d want 1", load_dat_q.size() - base); end
    if (load_dat_q.size() > base) begin
      lat = load_cyc_q[base] - t0;
      n_cmp++; if (lat < 949 || lat > 955) begin n_bad++; $display("FAIL single_latency: got %0d want 949..955", lat); end
    end
    n_cmp++; if (rx_data !== 8'hA5) begin n_bad++; $display("FAIL single_data: got %h want a5", rx_data); end
    n_cmp++; if (rx_vld !== 1'b1) begin n_bad++; $display("FAIL single_vld_held: got %b want 1", rx_vld); end
    rx_rdy = 1'b1;
    tick(1);
    rx_rdy = 1'b0;
    n_cmp++; if (rx_vld !== 1'b0) begin n_bad++; $display("FAIL single_vld_clear: got %b want 0", rx_vld); end
    tick(3);
    n_cmp++; if (rx_vld !== 1'b0) begin n_bad++; $display("FAIL single_rdy_idle: got %b want 0", rx_vld); end
  endtask

  task automatic test_back_to_back;
    int base, hb, fb, ob, t0;
    logic [7:0] exp_b [3];
    exp_b[0] = 8'h00; exp_b[1] = 8'hFF; exp_b[2] = 8'h3C;
    base = load_dat_q.size(); hb = vld_hi_cnt; fb = ferr_cnt; ob = ovr_cnt;
    rx_rdy = 1'b1;
    for (int k = 0; k < 3; k++) send_byte(exp_b[k], 1'b1, t0);
    tick(100);
    rx_rdy = 1'b0;
    n_cmp++; if (load_dat_q.size() - base !== 3) begin n_bad++; $display("FAIL b2b_count: got %0d want 3", load_dat_q.size() - base); end
    for (int k = 0; k < 3; k++) begin
      if (load_dat_q.size() > base + k) begin
        n_cmp++;
        if (load_dat_q[base + k] !== exp_b[k]) begin
          n_bad++; $display("FAIL b2b_data%0d: got %h want %h", k, load_dat_q[base + k], exp_b[k]);
        end
      end
    end
    n_cmp++; if (vld_hi_cnt - hb !== 3) begin n_bad++; $display("FAIL b2b_vld_cycles: got %0d want 3", vld_hi_cnt - hb); end
    n_cmp++; if (ferr_cnt - fb !== 0 || ovr_cnt - ob !== 0) begin n_bad++; $display("FAIL b2b_flags: ferr %0d ovr %0d want 0 0", ferr_cnt - fb, ovr_cnt - ob); end
  endtask

  task automatic test_overrun;
    int base, ob, fb, t1, t2, lat;
    base = load_dat_q.size(); ob = ovr_cnt; fb = ferr_cnt;
    rx_rdy = 1'b0;
    send_byte(8'h11, 1'b1, t1);
    send_byte(8'h22, 1'b1, t2);
    tick(50);
    n_cmp++; if (ovr_cnt - ob !== 1) begin n_bad++; $display("FAIL ovr_count: got %0d want 1", ovr_cnt - ob); end
    lat = ovr_cyc - t2;
    n_cmp++; if (lat < 949 || lat > 955) begin n_bad++; $display("FAIL ovr_timing: got %0d want 949..955", lat); end
    n_cmp++; if (rx_data !== 8'h11) begin n_bad++; $display("FAIL ovr_data_kept: got %h want 11", rx_data); end
    n_cmp++; if (rx_vld !== 1'b1) begin n_bad++; $display("FAIL ovr_vld_kept: got %b want 1", rx_vld); end
    n_cmp++; if (load_dat_q.size() - base !== 1) begin n_bad++; $display("FAIL ovr_loads: got %0d want 1", load_dat_q.size() - base); end
    n_cmp++; if (ferr_cnt - fb !== 0) begin n_bad++; $display("FAIL ovr_no_ferr: got %0d want 0", ferr_cnt - fb); end
    rx_rdy = 1'b1;
    tick(1);
    rx_rdy = 1'b0;
    n_cmp++; if (rx_vld !== 1'b0) begin n_bad++; $display("FAIL ovr_drain: got %b want 0", rx_vld); end
  endtask

  task automatic test_framing;
    int base, fb, ob, t0;
    base = load_dat_q.size(); fb = ferr_cnt; ob = ovr_cnt;
    rx_rdy = 1'b0;
    send_byte(8'h55, 1'b0, t0);
    tick(1500);
    n_cmp++; if (rx_busy !== 1'b1) begin n_bad++; $display("FAIL break_busy: got %b want 1", rx_busy); end
    tick(1500);
    n_cmp++; if (load_dat_q.size() - base !== 0) begin n_bad++; $display("FAIL ferr_no_vld: got %0d want 0", load_dat_q.size() - base); end
    rx = 1'b1;
    tick(200);
    n_cmp++; if (rx_busy !== 1'b0) begin n_bad++; $display("FAIL break_exit: got %b want 0", rx_busy); end
    send_byte(8'h81, 1'b1, t0);
    tick(50);
    n_cmp++; if (ferr_cnt - fb !== 1) begin n_bad++; $display("FAIL ferr_count: got %0d want 1", ferr_cnt - fb); end
    n_cmp++; if (ovr_cnt - ob !== 0) begin n_bad++; $display("FAIL ferr_no_ovr: got %0d want 0", ovr_cnt - ob); end
    n_cmp++; if (load_dat_q.size() - base !== 1) begin n_bad++; $display("FAIL ferr_next_count: got %0d want 1", load_dat_q.size() - base); end
    n_cmp++; if (rx_data !== 8'h81 || rx_vld !== 1'b1) begin n_bad++; $display("FAIL ferr_next_data: got %h/%b want 81/1", rx_data, rx_vld); end
    rx_rdy = 1'b1;
    tick(1);
    rx_rdy = 1'b0;
  endtask

  task automatic test_glitch_reset;
    int base, fb, t0;
    logic [7:0] b;
    base = load_dat_q.size(); fb = ferr_cnt;
    rx = 1'b0;
    tick(15);
    n_cmp++; if (rx_busy !== 1'b1) begin n_bad++; $display("FAIL glitch_start: got %b want 1", rx_busy); end
    tick(15);
    rx = 1'b1;
    tick(100);
    n_cmp++; if (rx_busy !== 1'b0) begin n_bad++; $display("FAIL glitch_reject: got %b want 0", rx_busy); end
    n_cmp++; if (load_dat_q.size() - base !== 0 || ferr_cnt - fb !== 0) begin n_bad++; $display("FAIL glitch_quiet: loads %0d ferr %0d want 0 0", load_dat_q.size() - base, ferr_cnt - fb); end
    // Start of 0x99, cut off by reset halfway through bit 4
    b = 8'h99;
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = b[4];
    tick(CPB / 2);
    n_cmp++; if (rx_busy !== 1'b1) begin n_bad++; $display("FAIL midframe_busy: got %b want 1", rx_busy); end
    rst_n = 1'b0;
    rx = 1'b1;
    tick(10);
    n_cmp++; if (rx_busy !== 1'b0 || rx_vld !== 1'b0) begin n_bad++; $display("FAIL midframe_reset: busy %b vld %b want 0 0", rx_busy, rx_vld); end
    rst_n = 1'b1;
    tick(300);
    n_cmp++; if (rx_busy !== 1'b0 || load_dat_q.size() - base !== 0) begin n_bad++; $display("FAIL midframe_abandon: busy %b loads %0d want 0 0", rx_busy, load_dat_q.size() - base); end
    send_byte(8'h42, 1'b1, t0);
    tick(50);
    n_cmp++; if (load_dat_q.size() - base !== 1) begin n_bad++; $display("FAIL after_reset_count: got %0d want 1", load_dat_q.size() - base); end
    n_cmp++; if (rx_data !== 8'h42 || rx_vld !== 1'b1) begin n_bad++; $display("FAIL after_reset_data: got %h/%b want 42/1", rx_data, rx_vld); end
    n_cmp++; if (ferr_cnt - fb !== 0) begin n_bad++; $display("FAIL after_reset_ferr: got %0d want 0", ferr_cnt - fb); end
    n_cmp++; if (both_cnt !== 0) begin n_bad++; $display("FAIL flags_exclusive: got %0d want 0", both_cnt); end
  endtask

  initial begin
    rst_n  = 1'b0;
    rx     = 1'b1;
    rx_rdy = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_framing();
    test_glitch_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
